// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the matrix keypad scanner
//
// Contents:
//   scan_state_e : scanner FSM states (IDLE, CHECK, ADVANCE)
//   key_event_t  : one queued key event {code, is_release}
//   key_width()  : bits needed to index n items (never less than 1)
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ADVANCE
    } scan_state_e;

    // Widest key code a scanner may emit; the top trims it to its own KW.
    localparam int CODE_W_MAX = 8;

    typedef struct packed {
        logic [CODE_W_MAX-1:0] code;
        logic                  is_release;
    } key_event_t;

    function automatic int key_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - synchronous event FIFO with registered occupancy
//
// Parameters: WIDTH entry width, DEPTH entries (power of two, >= 2)
// Ports:
//   clk, clear        clock, synchronous active-high reset
//   push, push_data   write request and entry
//   pop               read request; ignored while empty
//   head              oldest entry, forced to zero while empty
//   empty, full       occupancy flags decoded from the registered count
// A push while full is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("key_event_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with per-key debounce and event queue
//
// Optional feature: KEYPAD_RELEASE_EVENTS_EN (defined: releases are queued too)
// Ports:
//   clk          system clock
//   clear        synchronous active-high reset
//   row          raw active-low row lines, asynchronous
//   column       active-low column strobes, exactly one low
//   key_valid    event queue head is valid
//   key_ready    consumer takes the head this cycle
//   key_code     head key index = col*N_ROWS + row
//   key_release  head event is a release (0 when releases are not queued)
//   key_down     OR of all debounced key states
//   overflow     sticky: an event was dropped on a full queue
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS         = 3,
    parameter int N_COLS         = 3,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int KW            = key_width(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [N_ROWS-1:0] row,
    output logic [N_COLS-1:0] column,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [KW-1:0]     key_code,
    output logic              key_release,
    output logic              key_down,
    output logic              overflow
);

    localparam int N_KEYS   = N_ROWS * N_COLS;
    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int DW       = key_width(TICK_DIV);
    localparam int RW       = key_width(N_ROWS);
    localparam int CLW      = key_width(N_COLS);
    localparam int CW       = key_width(DEBOUNCE_SCANS);

    localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(N_COLS - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

`ifdef KEYPAD_RELEASE_EVENTS_EN
    localparam int FW = KW + 1;
`else
    localparam int FW = KW;
`endif

    // The row sweep must finish and the column must advance before the next tick.
    if (TICK_DIV < N_ROWS + 4) begin : g_tick_check
        $error("keypad_scanner: CLK_HZ/SCAN_HZ must be at least N_ROWS+4");
    end
    if (N_ROWS < 1 || N_COLS < 2 || DEBOUNCE_SCANS < 1) begin : g_shape_check
        $error("keypad_scanner: need N_ROWS>=1, N_COLS>=2, DEBOUNCE_SCANS>=1");
    end
    if (KW > CODE_W_MAX) begin : g_code_check
        $error("keypad_scanner: key code wider than key_event_t allows");
    end

    // Row synchroniser; stored inverted so 1 means pressed.
    logic [N_ROWS-1:0] row_meta;
    logic [N_ROWS-1:0] row_sync;

    always_ff @(posedge clk) begin
        if (clear) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= ~row;
            row_sync <= row_meta;
        end
    end

    // Scan tick divider.
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Scanner state.
    scan_state_e       state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CLW-1:0]    col_q, col_d;
    logic [N_ROWS-1:0] samp_q, samp_d;
    logic [N_KEYS-1:0] stable_q;
    logic [CW-1:0]     cnt_q [N_KEYS];

    logic [KW-1:0] chk_key;
    logic          cur_sample;
    logic          cur_stable;
    logic [CW-1:0] cur_cnt;
    logic          flip;
    logic          cnt_clr;
    logic          cnt_inc;

    assign chk_key    = KW'(int'(col_q) * N_ROWS + int'(r_q));
    assign cur_sample = samp_q[r_q];
    assign cur_stable = stable_q[chk_key];
    assign cur_cnt    = cnt_q[chk_key];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        col_d   = col_q;
        samp_d  = samp_q;
        flip    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    samp_d  = row_sync;
                    r_d     = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cur_sample == cur_stable) begin
                    cnt_clr = 1'b1;
                end else if (cur_cnt == CNT_LAST) begin
                    // This sample completes the run of differing samples.
                    flip    = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (r_q == ROW_LAST) begin
                    state_d = ADVANCE;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            ADVANCE: begin
                col_d   = (col_q == COL_LAST) ? '0 : col_q + CLW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            r_q      <= '0;
            col_q    <= '0;
            samp_q   <= '0;
            stable_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            col_q   <= col_d;
            samp_q  <= samp_d;
            if (flip) begin
                stable_q[chk_key] <= ~cur_stable;
            end
            if (cnt_clr) begin
                cnt_q[chk_key] <= '0;
            end else if (cnt_inc) begin
                cnt_q[chk_key] <= cur_cnt + CW'(1);
            end
        end
    end

    assign column   = ~(N_COLS'(1) << col_q);
    assign key_down = |stable_q;

    // Event assembly and queue.
    key_event_t    evt;
    logic          push;
    logic [FW-1:0] push_data;
    logic [FW-1:0] head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;

    always_comb begin
        evt            = '0;
        evt.code       = CODE_W_MAX'(chk_key);
        evt.is_release = ~cur_sample;
    end

`ifdef KEYPAD_RELEASE_EVENTS_EN
    assign push        = flip;
    assign push_data   = {KW'(evt.code), evt.is_release};
    assign key_code    = head[FW-1:1];
    assign key_release = head[0];
`else
    // Releases still flip stable state above but are not queued.
    assign push        = flip && !evt.is_release;
    assign push_data   = KW'(evt.code);
    assign key_code    = head;
    assign key_release = 1'b0;
`endif

    assign key_valid = !fifo_empty;
    assign pop       = key_ready;

    key_event_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !(key_valid && key_ready)) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [2:0] row;
    logic [2:0] column;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [3:0] key_code;
    logic       key_release;
    logic       key_down;
    logic       overflow;

    logic [8:0] keys = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .N_ROWS         (3),
        .N_COLS         (3),
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .row         (row),
        .column      (column),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_release (key_release),
        .key_down    (key_down),
        .overflow    (overflow)
    );

    // Keypad matrix: a held key pulls its row low while its column is strobed.
    always_comb begin
        row = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (column[c] == 1'b0 && keys[c*3+r]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_event(input string tag, input int code, input bit rel);
        int n = 0;
        while (key_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, key_valid, 1);
        check({tag, "_code"}, key_code, code);
        check({tag, "_release"}, key_release, rel);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic wait_col_enter(input string tag, input logic [2:0] pat);
        int n = 0;
        while (column === pat && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (column !== pat && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, column, pat);
    endtask

    task automatic wait_down_clear(input string tag);
        int n = 0;
        while (key_down !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_down, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] prev_col;
        logic       prev_down;
        int         dwell;
        int         changes;
        int         visits;
        int         n;
        bit         saw_valid;
        bit         saw_down;

        // Reset and idle sweep
        clear = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        check("rst_column", column, 3'b110);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_release", key_release, 0);
        check("rst_down", key_down, 0);
        check("rst_overflow", overflow, 0);

        prev_col  = column;
        dwell     = 0;
        changes   = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            dwell++;
            if (key_valid !== 1'b0) saw_valid = 1'b1;
            if (column !== prev_col) begin
                check("sweep_order", column, {prev_col[1:0], prev_col[2]});
                if (changes > 0) check("sweep_dwell", dwell, 10);
                changes++;
                dwell    = 0;
                prev_col = column;
            end
        end
        check("sweep_no_valid", saw_valid, 0);
        check("sweep_changes", (changes >= 18), 1);

        // Single press of key 7 (col 2, row 1)
        wait_col_enter("sp_align", 3'b110);
        keys[7]   = 1'b1;
        visits    = 0;
        prev_col  = column;
        prev_down = key_down;
        n         = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            prev_down = key_down;
            @(negedge clk);
            n++;
            if (column === 3'b011 && prev_col !== 3'b011) visits++;
            prev_col = column;
        end
        check("sp_visit", visits, 2);
        check("sp_column", column, 3'b011);
        check("sp_down_before", prev_down, 0);
        check("sp_down_after", key_down, 1);
        expect_event("sp", 7, 1'b0);
        keys[7] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
        expect_event("sp_rel", 7, 1'b1);
        check("sp_rel_down", key_down, 0);
`else
        wait_down_clear("sp_rel_down");
        expect_quiet("sp_rel_quiet", 40);
`endif

        // Bounce: key 4 held for one column-1 visit only
        wait_col_enter("bn_align", 3'b101);
        keys[4] = 1'b1;
        n = 0;
        while (column === 3'b101 && n < 50) begin
            @(negedge clk);
            n++;
        end
        keys[4]   = 1'b0;
        saw_valid = 1'b0;
        saw_down  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0) saw_valid = 1'b1;
            if (key_down !== 1'b0) saw_down = 1'b1;
        end
        check("bn_no_event", saw_valid, 0);
        check("bn_no_down", saw_down, 0);

        // Rows 0 and 2 of column 0 together, then released together
        wait_col_enter("sim_align", 3'b110);
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        expect_event("sim0", 0, 1'b0);
        expect_event("sim2", 2, 1'b0);
        check("sim_only_two", key_valid, 0);
        check("sim_down", key_down, 1);
        keys = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
        expect_event("sim_rel0", 0, 1'b1);
        expect_event("sim_rel2", 2, 1'b1);
        check("sim_rel_down", key_down, 0);
`else
        wait_down_clear("sim_rel_down");
        expect_quiet("sim_rel_quiet", 40);
`endif

        // Backpressure: five presses into a four-entry queue
        key_ready = 1'b0;
        wait_col_enter("bp_align", 3'b110);
        keys = 9'b0_0001_1111;
        n = 0;
        while (overflow !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_overflow", overflow, 1);
        check("bp_valid", key_valid, 1);
        check("bp_head", key_code, 0);
        repeat (20) @(negedge clk);
        check("bp_head_hold", key_code, 0);
        check("bp_head_hold_rel", key_release, 0);
        expect_event("bp0", 0, 1'b0);
        expect_event("bp1", 1, 1'b0);
        expect_event("bp2", 2, 1'b0);
        expect_event("bp3", 3, 1'b0);
        check("bp_fifth_dropped", key_valid, 0);
        check("bp_overflow_sticky", overflow, 1);

        // Release everything with the consumer always ready
        key_ready = 1'b1;
        keys = '0;
        wait_down_clear("rel_all_down");
        repeat (5) @(negedge clk);
        key_ready = 1'b0;
        check("rel_all_empty", key_valid, 0);
        check("rel_all_overflow", overflow, 1);

        // Clear while three events are queued and keys 6,7,8 are held
        keys = 9'b1_1100_0000;
        n = 0;
        while (key_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rm_valid_before", key_valid, 1);
        check("rm_head_before", key_code, 6);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("rm_valid", key_valid, 0);
        check("rm_overflow", overflow, 0);
        check("rm_down", key_down, 0);
        check("rm_column", column, 3'b110);
        expect_event("rm6", 6, 1'b0);
        expect_event("rm7", 7, 1'b0);
        expect_event("rm8", 8, 1'b0);
        expect_quiet("rm_quiet", 60);
        check("rm_down_held", key_down, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
